// File: rtl/drv_pwr_seq_if.sv
// Bus between the drive power sequencer and the backplane: power enable,
// per-drive presence/power-good inputs and per-drive enable/status outputs.
interface drv_pwr_seq_if;
    logic        PWR_SEQ_EN;
    logic [23:0] DRV_PRSNT_N;
    logic [23:0] DRV_PWRGD;
    logic [23:0] DRV_PWR_EN;
    logic [23:0] DRV_PWROK;
    logic [23:0] DRV_FAULT;
    logic        SEQ_BUSY;

    modport master (
        output PWR_SEQ_EN,
        output DRV_PRSNT_N,
        output DRV_PWRGD,
        input  DRV_PWR_EN,
        input  DRV_PWROK,
        input  DRV_FAULT,
        input  SEQ_BUSY
    );

    modport slave (
        input  PWR_SEQ_EN,
        input  DRV_PRSNT_N,
        input  DRV_PWRGD,
        output DRV_PWR_EN,
        output DRV_PWROK,
        output DRV_FAULT,
        output SEQ_BUSY
    );
endinterface

// File: rtl/drv_pwr_seq.sv
// Staggered hot-swap power sequencer for 24 drive bays: debounces presence,
// enables one drive at a time, watches power-good and latches per-drive faults.
module drv_pwr_seq #(
    parameter logic [31:0] T_DEB  = 32'd2500000,
    parameter logic [31:0] T_PGTO = 32'd5000000,
    parameter logic [31:0] T_GAP  = 32'd1250000
) (
    input logic           SYSCLK,
    input logic           RESET_N,
    drv_pwr_seq_if.slave  bus
);

    localparam int N = 24;
    localparam logic [31:0] DebLast  = (T_DEB  == 32'd0) ? 32'd0 : T_DEB  - 32'd1;
    localparam logic [31:0] PgtoLast = (T_PGTO == 32'd0) ? 32'd0 : T_PGTO - 32'd1;
    localparam logic [31:0] GapLast  = (T_GAP  == 32'd0) ? 32'd0 : T_GAP  - 32'd1;

    typedef enum logic [2:0] {
        IDLE,
        SCAN,
        ENABLE,
        WAIT_PG,
        GAP
    } state_e;

    state_e      state_q, state_d;
    logic [4:0]  idx_q, idx_d;
    logic [31:0] timer_q, timer_d;

    logic [N-1:0] prsntMeta_q, prsntSync_q;
    logic [N-1:0] pgMeta_q, pgSync_q;
    logic [N-1:0] present_q, present_d;
    logic [31:0]  debCnt_q [N];
    logic [31:0]  debCnt_d [N];

    logic [N-1:0] en_q, en_d;
    logic [N-1:0] pwrOk_q, pwrOk_d;
    logic [N-1:0] fault_q, fault_d;

    logic [4:0]  nextIdx;
    logic [31:0] timerInc;

    // Presence syncs reset to "absent" so a bay never looks populated out of reset.
    always_ff @(posedge SYSCLK or negedge RESET_N) begin
        if (!RESET_N) begin
            prsntMeta_q <= '1;
            prsntSync_q <= '1;
            pgMeta_q    <= '0;
            pgSync_q    <= '0;
        end else begin
            prsntMeta_q <= bus.DRV_PRSNT_N;
            prsntSync_q <= prsntMeta_q;
            pgMeta_q    <= bus.DRV_PWRGD;
            pgSync_q    <= pgMeta_q;
        end
    end

    always_comb begin
        present_d = present_q;
        for (int i = 0; i < N; i++) begin
            debCnt_d[i] = '0;
            if (prsntSync_q[i] == present_q[i]) begin
                if (debCnt_q[i] >= DebLast) begin
                    present_d[i] = ~prsntSync_q[i];
                end else begin
                    debCnt_d[i] = debCnt_q[i] + 32'd1;
                end
            end
        end
    end

    assign nextIdx  = (idx_q == 5'd23) ? 5'd0 : idx_q + 5'd1;
    assign timerInc = (timer_q == '1) ? timer_q : timer_q + 32'd1;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        timer_d = timer_q;
        en_d    = en_q;
        fault_d = fault_q;

        case (state_q)
            IDLE: begin
                if (bus.PWR_SEQ_EN) state_d = SCAN;
            end
            SCAN: begin
                if (present_q[idx_q] && !en_q[idx_q] && !fault_q[idx_q]) begin
                    state_d = ENABLE;
                end else begin
                    idx_d = nextIdx;
                end
            end
            ENABLE: begin
                en_d[idx_q] = 1'b1;
                timer_d     = '0;
                state_d     = WAIT_PG;
            end
            WAIT_PG: begin
                if (!present_q[idx_q] || pgSync_q[idx_q]) begin
                    timer_d = '0;
                    state_d = GAP;
                end else if (timer_q >= PgtoLast) begin
                    en_d[idx_q]    = 1'b0;
                    fault_d[idx_q] = 1'b1;
                    timer_d        = '0;
                    state_d        = GAP;
                end else begin
                    timer_d = timerInc;
                end
            end
            GAP: begin
                if (timer_q >= GapLast) begin
                    idx_d   = nextIdx;
                    timer_d = '0;
                    state_d = SCAN;
                end else begin
                    timer_d = timerInc;
                end
            end
            default: state_d = IDLE;
        endcase

        // The drive under WAIT_PG is still ramping, so its low power-good is not a loss.
        for (int i = 0; i < N; i++) begin
            if (en_q[i] && !pgSync_q[i] && !(state_q == WAIT_PG && idx_q == 5'(i))) begin
                en_d[i]    = 1'b0;
                fault_d[i] = 1'b1;
            end
        end

        // Removal overrides any fault raised in the same cycle and re-arms the bay.
        for (int i = 0; i < N; i++) begin
            if (!present_q[i]) begin
                en_d[i]    = 1'b0;
                fault_d[i] = 1'b0;
            end
        end

        if (!bus.PWR_SEQ_EN) begin
            state_d = IDLE;
            idx_d   = '0;
            timer_d = '0;
            en_d    = '0;
            fault_d = '0;
        end

        pwrOk_d = en_d & pgSync_q & ~fault_d;
    end

    always_ff @(posedge SYSCLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q   <= IDLE;
            idx_q     <= '0;
            timer_q   <= '0;
            present_q <= '0;
            en_q      <= '0;
            pwrOk_q   <= '0;
            fault_q   <= '0;
            for (int i = 0; i < N; i++) debCnt_q[i] <= '0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            timer_q   <= timer_d;
            present_q <= present_d;
            en_q      <= en_d;
            pwrOk_q   <= pwrOk_d;
            fault_q   <= fault_d;
            for (int i = 0; i < N; i++) debCnt_q[i] <= debCnt_d[i];
        end
    end

    assign bus.DRV_PWR_EN = en_q;
    assign bus.DRV_PWROK  = pwrOk_q;
    assign bus.DRV_FAULT  = fault_q;
    assign bus.SEQ_BUSY   = (state_q != IDLE);

endmodule

// File: tb/tb_drv_pwr_seq.sv
// Directed bench for drv_pwr_seq with shortened timers; drive power-good is
// looped back from the enables through a per-bay mask.
module tb_drv_pwr_seq;

    localparam logic [31:0] T_DEB  = 32'd8;
    localparam logic [31:0] T_PGTO = 32'd40;
    localparam logic [31:0] T_GAP  = 32'd10;

    logic        SYSCLK = 1'b0;
    logic        RESET_N;
    logic [23:0] prsntN;
    logic [23:0] pgMask;
    int          vectors = 0;
    int          miscompares = 0;
    int          cyc;

    drv_pwr_seq_if bus();

    drv_pwr_seq #(
        .T_DEB  (T_DEB),
        .T_PGTO (T_PGTO),
        .T_GAP  (T_GAP)
    ) dut (
        .SYSCLK  (SYSCLK),
        .RESET_N (RESET_N),
        .bus     (bus)
    );

    always #5 SYSCLK = ~SYSCLK;

    // A healthy hot-swap controller reports power-good as soon as it is enabled.
    assign bus.DRV_PWRGD = bus.DRV_PWR_EN & pgMask;

    task automatic stepCycles(input int n);
        repeat (n) @(posedge SYSCLK);
        #1;
    endtask

    task automatic applyStimulus(input logic seqEn, input logic [23:0] prN, input int cycles);
        bus.PWR_SEQ_EN  = seqEn;
        bus.DRV_PRSNT_N = prN;
        stepCycles(cycles);
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic selBit(input int sel, input int b);
        case (sel)
            0:       return bus.DRV_PWR_EN[b];
            1:       return bus.DRV_PWROK[b];
            default: return bus.DRV_FAULT[b];
        endcase
    endfunction

    // sel: 0 = enable, 1 = power-ok, 2 = fault
    task automatic waitBit(input string tag, input int sel, input int b, input logic lvl,
                           input int budget, output int cycles);
        cycles = 0;
        while (selBit(sel, b) !== lvl && cycles < budget) begin
            stepCycles(1);
            cycles++;
        end
        checkOutput(tag, 32'(selBit(sel, b)), 32'(lvl));
    endtask

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        RESET_N = 1'b0;
        prsntN  = '1;
        pgMask  = '1;
        bus.PWR_SEQ_EN  = 1'b0;
        bus.DRV_PRSNT_N = prsntN;
        #23;
        checkOutput("rst_en",    32'(bus.DRV_PWR_EN), 32'h0);
        checkOutput("rst_pwrok", 32'(bus.DRV_PWROK),  32'h0);
        checkOutput("rst_fault", 32'(bus.DRV_FAULT),  32'h0);
        checkOutput("rst_busy",  32'(bus.SEQ_BUSY),   32'h0);
        stepCycles(1);
        RESET_N = 1'b1;

        $display("[TB] stagger of drives 0, 5, 23");
        prsntN[0] = 1'b0; prsntN[5] = 1'b0; prsntN[23] = 1'b0;
        applyStimulus(1'b0, prsntN, 15);
        checkOutput("idle_en",   32'(bus.DRV_PWR_EN), 32'h0);
        checkOutput("idle_busy", 32'(bus.SEQ_BUSY),   32'h0);
        applyStimulus(1'b1, prsntN, 0);
        waitBit("en0_rise", 0, 0, 1'b1, 50, cyc);
        checkOutput("en0_lat", 32'(cyc), 32'd3);
        checkOutput("en0_only", 32'(bus.DRV_PWR_EN), 32'h000001);
        waitBit("pwrok0_rise", 1, 0, 1'b1, 20, cyc);
        checkOutput("pwrok0_lat", 32'(cyc), 32'd3);
        waitBit("en5_rise", 0, 5, 1'b1, 100, cyc);
        checkOutput("en5_gap", 32'(cyc), 32'd16);
        checkOutput("en5_vec", 32'(bus.DRV_PWR_EN), 32'h000021);
        waitBit("en23_rise", 0, 23, 1'b1, 100, cyc);
        checkOutput("en23_gap", 32'(cyc), 32'd32);
        stepCycles(3);
        checkOutput("pwrok_3", 32'(bus.DRV_PWROK), 32'h800021);
        checkOutput("fault_0", 32'(bus.DRV_FAULT), 32'h0);
        checkOutput("busy_on", 32'(bus.SEQ_BUSY),  32'h1);

        $display("[TB] power-good loss on drive 3");
        prsntN[3] = 1'b0;
        applyStimulus(1'b1, prsntN, 0);
        waitBit("en3_rise", 0, 3, 1'b1, 200, cyc);
        waitBit("pwrok3_rise", 1, 3, 1'b1, 20, cyc);
        pgMask[3] = 1'b0;
        stepCycles(2);
        checkOutput("pgloss_en_hold",    32'(bus.DRV_PWR_EN), 32'h800029);
        checkOutput("pgloss_pwrok_hold", 32'(bus.DRV_PWROK),  32'h800029);
        stepCycles(1);
        checkOutput("pgloss_en",    32'(bus.DRV_PWR_EN), 32'h800021);
        checkOutput("pgloss_pwrok", 32'(bus.DRV_PWROK),  32'h800021);
        checkOutput("pgloss_fault", 32'(bus.DRV_FAULT),  32'h000008);

        $display("[TB] power-good timeout on drive 7");
        pgMask[7] = 1'b0;
        prsntN[7] = 1'b0;
        applyStimulus(1'b1, prsntN, 0);
        waitBit("en7_rise", 0, 7, 1'b1, 200, cyc);
        waitBit("en7_drop", 0, 7, 1'b0, 100, cyc);
        checkOutput("pgto_lat",   32'(cyc), 32'd40);
        checkOutput("pgto_fault", 32'(bus.DRV_FAULT), 32'h000088);
        stepCycles(100);
        checkOutput("pgto_no_retry", 32'(bus.DRV_PWR_EN), 32'h800021);
        prsntN[7] = 1'b1;
        applyStimulus(1'b1, prsntN, 0);
        waitBit("fault7_clear", 2, 7, 1'b0, 50, cyc);
        checkOutput("fault7_clear_lat", 32'(cyc), 32'd11);
        pgMask[7] = 1'b1;
        prsntN[7] = 1'b0;
        applyStimulus(1'b1, prsntN, 0);
        waitBit("en7_reinsert", 0, 7, 1'b1, 200, cyc);
        checkOutput("en7_reinsert_fault", 32'(bus.DRV_FAULT), 32'h000008);

        $display("[TB] removal of drive 10 while waiting for power-good");
        pgMask[10] = 1'b0;
        prsntN[10] = 1'b0;
        applyStimulus(1'b1, prsntN, 0);
        waitBit("en10_rise", 0, 10, 1'b1, 200, cyc);
        prsntN[10] = 1'b1;
        prsntN[11] = 1'b0;
        applyStimulus(1'b1, prsntN, 0);
        waitBit("en10_drop", 0, 10, 1'b0, 50, cyc);
        checkOutput("remove_lat",   32'(cyc), 32'd11);
        checkOutput("remove_fault", 32'(bus.DRV_FAULT), 32'h000008);
        waitBit("en11_rise", 0, 11, 1'b1, 50, cyc);
        checkOutput("resume_at_11", 32'(cyc), 32'd12);
        pgMask[10] = 1'b1;

        $display("[TB] bouncing presence on drive 15");
        for (int k = 0; k < 12; k++) begin
            prsntN[15] = (k % 2 == 0) ? 1'b0 : 1'b1;
            applyStimulus(1'b1, prsntN, 5);
        end
        checkOutput("bounce_no_en", 32'(bus.DRV_PWR_EN[15]), 32'h0);
        prsntN[15] = 1'b0;
        applyStimulus(1'b1, prsntN, 0);
        waitBit("bounce_stable_en", 0, 15, 1'b1, 200, cyc);
        checkOutput("bounce_deb_min", 32'(cyc >= 10), 32'h1);

        $display("[TB] sequencing disable with 12 drives on");
        prsntN[1] = 1'b0; prsntN[2] = 1'b0; prsntN[4] = 1'b0;
        prsntN[6] = 1'b0; prsntN[8] = 1'b0; prsntN[9] = 1'b0;
        applyStimulus(1'b1, prsntN, 400);
        checkOutput("twelve_en",    32'(bus.DRV_PWR_EN), 32'h808BF7);
        checkOutput("twelve_pwrok", 32'(bus.DRV_PWROK),  32'h808BF7);
        checkOutput("twelve_fault", 32'(bus.DRV_FAULT),  32'h000008);
        pgMask[3] = 1'b1;
        applyStimulus(1'b0, prsntN, 1);
        checkOutput("dis_en",    32'(bus.DRV_PWR_EN), 32'h0);
        checkOutput("dis_pwrok", 32'(bus.DRV_PWROK),  32'h0);
        checkOutput("dis_fault", 32'(bus.DRV_FAULT),  32'h0);
        checkOutput("dis_busy",  32'(bus.SEQ_BUSY),   32'h0);
        applyStimulus(1'b0, prsntN, 5);
        applyStimulus(1'b1, prsntN, 0);
        waitBit("restart_en0", 0, 0, 1'b1, 50, cyc);
        checkOutput("restart_lat", 32'(cyc), 32'd3);
        checkOutput("restart_vec", 32'(bus.DRV_PWR_EN), 32'h000001);

        $display("[TB] reset asserted mid-sequence");
        stepCycles(2);
        RESET_N = 1'b0;
        #1;
        checkOutput("midrst_en",    32'(bus.DRV_PWR_EN), 32'h0);
        checkOutput("midrst_pwrok", 32'(bus.DRV_PWROK),  32'h0);
        checkOutput("midrst_busy",  32'(bus.SEQ_BUSY),   32'h0);
        applyStimulus(1'b0, prsntN, 3);
        RESET_N = 1'b1;
        applyStimulus(1'b0, prsntN, 15);
        checkOutput("postrst_en", 32'(bus.DRV_PWR_EN), 32'h0);
        applyStimulus(1'b1, prsntN, 0);
        waitBit("postrst_en0", 0, 0, 1'b1, 50, cyc);
        checkOutput("postrst_lat", 32'(cyc), 32'd3);
        checkOutput("postrst_vec", 32'(bus.DRV_PWR_EN), 32'h000001);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
